// File: rtl/uart_pkg.sv
// Shared definitions for the programmable-period serial link (receive and transmit sides).
package uart_pkg;

    // Receiver frame states.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Shortest usable bit period in clocks; smaller time_set values are raised to this.
    localparam int MIN_PERIOD = 4;

    // Data bits per frame, common to both ends of the link.
    localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line plus 1->0 start-edge detection.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic start_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;

    // Shift the raw line through the chain and remember the previous synchronized level.
    // Everything resets to 1 (idle line) so leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: clocked state is always written with <=, so every flop sees the pre-edge values.
            sync_q <= '1;
            prev   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            prev   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = prev & ~rx_s;

endmodule

// File: rtl/uart_serial_rx.sv
// 8N1 serial receiver with a runtime bit period; emits each byte with a one-cycle valid pulse.
module uart_serial_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CNT_W-1:0]     time_set,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     period;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     half;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
    logic                 start_edge;
    logic                 half_hit;
    logic                 bit_hit;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_s       (rx_s),
        .start_edge (start_edge)
    );

    // Sample points: middle of the start bit, then one full period later for every further bit.
    assign half     = period >> 1;
    assign half_hit = (cnt == half - CNT_W'(1));
    assign bit_hit  = (cnt == period - CNT_W'(1));

    // Frame FSM with bit counter, shift register and registered output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            period    <= '0;
            cnt       <= '0;
            bit_idx   <= '0;
            // NOTE: the shift register is a plain register, not a memory array, so it is reset like the rest.
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_edge) begin
                        // Period is frozen for the whole frame; time_set changes mid-frame are ignored.
                        period <= (time_set < MIN_P) ? MIN_P : time_set;
                        state  <= START;
                        busy   <= 1'b1;
                    end
                end

                START: begin
                    if (half_hit) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Line already back high: a glitch, not a start bit.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_hit) begin
                        cnt     <= '0;
                        // LSB arrives first, so new bits enter at the top and slide down.
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (bit_hit) begin
                        // Back to IDLE mid stop bit so a frame starting right after is caught.
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rx_s) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_serial_rx.sv
// Self-checking bench for uart_serial_rx: directed scenarios plus randomized frames,
// compared against an event-level model of what the receiver must report.
module tb_uart_serial_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] time_set;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Event model: each entry is {is_frame_error, rx_data seen with the pulse}.
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    logic [7:0] last_good = 8'h00;

    int  busy_run      = 0;
    int  last_busy_len = 0;
    logic prev_pulse   = 1'b0;

    uart_serial_rx #(
        .DATA_BITS   (8),
        .CNT_W       (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .time_set  (time_set),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; inputs change 1 time unit after the rising edge.
    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one 8N1 frame, p clocks per bit.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int p);
        rx = 1'b0;
        hold(p);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            hold(p);
        end
        rx = stop;
        hold(p);
    endtask

    // Model: a good stop bit reports the byte; a bad one reports an error with the old byte.
    task automatic expect_frame(input logic [7:0] data, input logic stop);
        if (stop) begin
            exp_q.push_back({1'b0, data});
            last_good = data;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
    endtask

    // Wait (bounded) for the expected events, then compare them in order.
    task automatic compare_events(input string tag);
        int wait_cnt;
        int n;
        logic [8:0] o;
        logic [8:0] e;
        wait_cnt = 0;
        while (obs_q.size() < exp_q.size() && wait_cnt < 400) begin
            hold(1);
            wait_cnt++;
        end
        hold(4);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_kind"}, 32'(o[8]), 32'(e[8]));
            check({tag, "_data"}, 32'(o[7:0]), 32'(e[7:0]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Monitor on the falling edge: collect pulses, check their shape, measure busy length.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid || frame_err) begin
                check("pulse_shape", 32'({rx_valid & frame_err, prev_pulse}), 32'(0));
                obs_q.push_back({frame_err, rx_data});
            end
            prev_pulse = rx_valid | frame_err;
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run      = 0;
            end
        end else begin
            prev_pulse = 1'b0;
            busy_run   = 0;
        end
    end

    // Watchdog against a hung run.
    initial begin
        #600000;
        $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        int gap;
        logic [7:0] d;
        logic stop;

        rx       = 1'b1;
        reset    = 1'b1;
        time_set = 32'd16;
        hold(4);
        check("rst_rx_data", 32'(rx_data), 32'(0));
        check("rst_rx_valid", 32'(rx_valid), 32'(0));
        check("rst_frame_err", 32'(frame_err), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        hold(5);
        check("idle_busy", 32'(busy), 32'(0));

        // Good frame 0xA5 at 16 clocks/bit; busy lasts half + 9 periods.
        expect_frame(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1, 16);
        hold(16);
        compare_events("a5");
        check("a5_busy_len", 32'(last_busy_len), 32'(16 / 2 + 9 * 16));

        // Bad stop bit, then the line stays low: one error, no further frame.
        expect_frame(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0, 16);
        hold(40);
        check("stuck_low_busy", 32'(busy), 32'(0));
        compare_events("3c_err");
        check("err_hold_data", 32'(rx_data), 32'(last_good));
        rx = 1'b1;
        hold(20);
        check("after_low_busy", 32'(busy), 32'(0));
        compare_events("after_low");

        // Three-cycle glitch: receiver starts, rejects it at mid start bit.
        rx = 1'b0;
        hold(3);
        check("glitch_busy_high", 32'(busy), 32'(1));
        rx = 1'b1;
        hold(20);
        check("glitch_busy_low", 32'(busy), 32'(0));
        compare_events("glitch");

        // Back-to-back frames, single stop bit each.
        time_set = 32'd10;
        expect_frame(8'h00, 1'b1);
        expect_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1, 10);
        send_frame(8'hFF, 1'b1, 10);
        hold(20);
        compare_events("b2b");

        // Reset in the middle of bit 4 of 0x55, then a clean 0x81.
        time_set = 32'd16;
        d        = 8'h55;
        rx       = 1'b0;
        hold(16);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            hold(16);
        end
        rx = d[4];
        hold(8);
        reset = 1'b1;
        hold(1);
        reset = 1'b0;
        rx    = 1'b1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_rx_data", 32'(rx_data), 32'(0));
        check("midrst_pulses", 32'({rx_valid, frame_err}), 32'(0));
        last_good = 8'h00;
        hold(30);
        compare_events("midrst_none");
        expect_frame(8'h81, 1'b1);
        send_frame(8'h81, 1'b1, 16);
        hold(16);
        compare_events("after_rst_81");

        // Period below minimum is clamped; a time_set change mid-frame is ignored.
        time_set = 32'd2;
        expect_frame(8'h96, 1'b1);
        fork
            send_frame(8'h96, 1'b1, 4);
            begin
                hold(20);
                time_set = 32'd100;
            end
        join
        hold(10);
        compare_events("clamp_96");
        check("clamp_rx_data", 32'(rx_data), 32'(8'h96));

        // Randomized frames: random data, period, stop-bit quality and idle gap.
        for (int k = 0; k < 12; k++) begin
            p = $urandom_range(4, 24);
            if (p == 4 && $urandom_range(0, 1) == 1) begin
                time_set = 32'($urandom_range(0, 3));
            end else begin
                time_set = 32'(p);
            end
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            gap  = $urandom_range(p, 2 * p);
            expect_frame(d, stop);
            send_frame(d, stop, p);
            rx = 1'b1;
            hold(gap);
            compare_events("rand");
        end
        check("final_busy", 32'(busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_serial_rx.md
Name: uart_serial_rx

Overview:
Receiving end of the team's programmable-period serial line. Samples an asynchronous 1-bit line and recovers 8N1 frames: start bit low, DATA_BITS data bits LSB-first, one stop bit high. The bit period in clocks comes from a runtime word, as on the transmit side. Each recovered byte goes to the downstream register/FIFO with a one-cycle valid pulse, plus a framing-error flag.

Parameters:
DATA_BITS, 8, data bits per frame, sent LSB first.
CNT_W, 32, width of the bit-period word and the internal bit counter.
SYNC_STAGES, 2, flops in the rx metastability synchronizer (minimum 2).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous reset, active-high.
time_set  input  CNT_W  clocks per bit period.
rx  input  1  asynchronous serial line; idle high.
rx_data  output  DATA_BITS  last received byte.
rx_valid  output  1  one-cycle pulse: rx_data updated, stop bit good.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
busy  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high.
- Reset values:
  - rx_data = 0, rx_valid = 0, frame_err = 0, busy = 0.
  - State = IDLE; counters = 0.
  - Synchronizer flops and the edge-detect history = 1 (line idle), so releasing reset never fakes a start bit.
- Synchronizer: rx passes through SYNC_STAGES flops; rx_s is the last stage. A start edge is rx_s = 0 while the previous rx_s = 1.
- Period latch: time_set is captured into `period` on the start-edge cycle. Values below 4 are clamped to 4. Changes to time_set mid-frame are ignored. half = period >> 1.
- Bit counter `cnt`:
  - Clears to 0 on entry to each state.
  - Increments every cycle otherwise.
  - A compare hit clears it.
- States:
  - IDLE: on a start edge, latch period and go to START.
  - START: at cnt == half-1 (mid start bit), sample rx_s.
    - rx_s = 0: go to DATA with bit index 0.
    - rx_s = 1: glitch; return to IDLE with no outputs.
  - DATA: at cnt == period-1, shift rx_s into the shift register MSB side (LSB-first reception). Increment the bit index. After bit DATA_BITS-1, go to STOP.
  - STOP: at cnt == period-1, sample rx_s.
    - rx_s = 1: next cycle rx_data <= shift register, rx_valid = 1.
    - rx_s = 0: next cycle frame_err = 1; rx_data is unchanged.
    - Either way, return to IDLE on the sampling cycle. That cycle is mid stop bit, so back-to-back frames are caught.
- Output timing:
  - rx_valid and frame_err are registered, exactly one cycle wide, and mutually exclusive.
  - rx_data holds its value until the next good frame.
- busy: asserted the cycle after the start edge; deasserted the cycle after the stop sample.
- Line stuck low after a frame error: no new start is taken until rx_s has been seen high (edge detection requires a 1->0 transition).
- Reset mid-frame: abandon the frame, apply reset values, no pulse emitted.
- Simultaneous reset and stop sample: reset wins.

Decomposition:
- Shared package uart_pkg:
  - State enum {IDLE, START, DATA, STOP}.
  - MIN_PERIOD = 4.
  - Default DATA_BITS constant (shared with the transmitter).
- Sub-module uart_rx_sync: SYNC_STAGES synchronizer with reset-to-1 plus falling-edge detect; outputs rx_s and start_edge.
- The FSM, counters and shift register stay in uart_serial_rx.

Test Plan:
- time_set = 16, drive frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first), stop high -> exactly one rx_valid pulse, rx_data = 0xA5, frame_err stays 0, busy high for about 9.5 bit periods.
- time_set = 16, frame 0x3C with stop bit low -> one frame_err pulse, no rx_valid, rx_data keeps its previous value. Then hold rx low for 40 cycles -> no new frame until rx returns high.
- time_set = 16, 3-cycle low glitch on an idle line -> START rejects it, busy returns to 0, no pulses.
- Back-to-back frames 0x00 then 0xFF with a single stop bit, time_set = 10 -> two rx_valid pulses, with rx_data 0x00 then 0xFF.
- Assert reset for 1 cycle during bit 4 of 0x55 -> outputs and busy go to 0. A following full 0x81 frame is received correctly with one rx_valid.
- time_set = 2 (clamped to 4), frame 0x96 driven at 4 clocks/bit -> rx_data = 0x96. Changing time_set to 100 mid-frame does not disturb reception.
